// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, flush/stall control, operand forwarding
// and data-memory wait tracking with timeout for the 5-stage pipeline.
// Optional feature macro: HAZARD_PERF_CNT_EN (builds the saturating
// stall/flush/wait performance counters; otherwise the counter outputs are 0).
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       i_ifid_rs,
  input  logic [4:0]       i_ifid_rt,
  input  logic [4:0]       i_idex_rs,
  input  logic [4:0]       i_idex_rt,
  input  logic             i_idex_mem_read,
  input  logic [4:0]       i_exmem_write_reg,
  input  logic [4:0]       i_memwb_write_reg,
  input  logic             i_exmem_reg_write,
  input  logic             i_memwb_reg_write,
  input  logic             i_exmem_branch,
  input  logic             i_exmem_zero,
  input  logic             i_exmem_mem_access,
  input  logic             i_dmem_ready,
  output logic             o_pc_write,
  output logic             o_ifid_write,
  output logic             o_if_flush,
  output logic             o_id_bubble,
  output logic             o_ex_flush,
  output logic             o_pc_src,
  output logic             o_pipe_hold,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
  output logic [CNT_W-1:0] o_wait_cnt
);

  localparam int unsigned WCNT_W = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              mem_err_q;

  logic taken;
  logic loaduse;
  logic mwait;

  // Hazard conditions decoded from the pipeline register tags
  assign taken   = i_exmem_branch & i_exmem_zero;
  assign loaduse = i_idex_mem_read & (i_idex_rt != 5'd0) &
                   ((i_idex_rt == i_ifid_rs) | (i_idex_rt == i_ifid_rt));
  assign mwait   = i_exmem_mem_access & ~i_dmem_ready;

  // State, wait counter and sticky error registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_RUN;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_q | (state_d == ST_ERR);
    end
  end

  assign o_mem_err = mem_err_q;

  // Next-state: count consecutive not-ready cycles, give up after WAIT_MAX
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_RUN: begin
        if (mwait) begin
          state_d = ST_MWAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      ST_MWAIT: begin
        if (i_dmem_ready) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_W'(WAIT_MAX)) begin
          state_d = ST_ERR;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // Pipeline controls: error/memory hold, then branch flush, then load-use stall
  always_comb begin
    o_pc_write   = 1'b1;
    o_ifid_write = 1'b1;
    o_if_flush   = 1'b0;
    o_id_bubble  = 1'b0;
    o_ex_flush   = 1'b0;
    o_pc_src     = 1'b0;
    o_pipe_hold  = 1'b0;
    if ((state_q == ST_ERR) || mwait) begin
      o_pipe_hold  = 1'b1;
      o_pc_write   = 1'b0;
      o_ifid_write = 1'b0;
    end else if (taken) begin
      o_pc_src    = 1'b1;
      o_if_flush  = 1'b1;
      o_id_bubble = 1'b1;
      o_ex_flush  = 1'b1;
    end else if (loaduse) begin
      o_pc_write   = 1'b0;
      o_ifid_write = 1'b0;
      o_id_bubble  = 1'b1;
    end
  end

  // Operand forwarding; the younger EX/MEM result wins over MEM/WB
  always_comb begin
    o_fwd_a = 2'b00;
    o_fwd_b = 2'b00;
    if (i_exmem_reg_write && (i_exmem_write_reg != 5'd0) &&
        (i_exmem_write_reg == i_idex_rs)) begin
      o_fwd_a = 2'b10;
    end else if (i_memwb_reg_write && (i_memwb_write_reg != 5'd0) &&
                 (i_memwb_write_reg == i_idex_rs)) begin
      o_fwd_a = 2'b01;
    end
    if (i_exmem_reg_write && (i_exmem_write_reg != 5'd0) &&
        (i_exmem_write_reg == i_idex_rt)) begin
      o_fwd_b = 2'b10;
    end else if (i_memwb_reg_write && (i_memwb_write_reg != 5'd0) &&
                 (i_memwb_write_reg == i_idex_rt)) begin
      o_fwd_b = 2'b01;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic             stall_evt;
  logic             flush_evt;
  logic             wait_evt;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] wait_cnt_q;

  // A stall is a bubble without a redirect; a flush is a redirect
  assign stall_evt = o_id_bubble & ~o_pc_src;
  assign flush_evt = o_pc_src;
  assign wait_evt  = o_pipe_hold;

  // Saturating event counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (stall_evt && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (wait_evt  && !(&wait_cnt_q))  wait_cnt_q  <= wait_cnt_q  + CNT_W'(1);
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
  assign o_wait_cnt  = wait_cnt_q;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
  assign o_wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (WAIT_MAX=4).
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 16;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             i_clk;
  logic             i_rst_n;
  logic [4:0]       i_ifid_rs, i_ifid_rt, i_idex_rs, i_idex_rt;
  logic             i_idex_mem_read;
  logic [4:0]       i_exmem_write_reg, i_memwb_write_reg;
  logic             i_exmem_reg_write, i_memwb_reg_write;
  logic             i_exmem_branch, i_exmem_zero, i_exmem_mem_access, i_dmem_ready;
  logic             o_pc_write, o_ifid_write, o_if_flush, o_id_bubble, o_ex_flush;
  logic             o_pc_src, o_pipe_hold, o_mem_err;
  logic [1:0]       o_fwd_a, o_fwd_b;
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt, o_wait_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.WAIT_MAX(4), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ifid_rs(i_ifid_rs), .i_ifid_rt(i_ifid_rt),
    .i_idex_rs(i_idex_rs), .i_idex_rt(i_idex_rt),
    .i_idex_mem_read(i_idex_mem_read),
    .i_exmem_write_reg(i_exmem_write_reg), .i_memwb_write_reg(i_memwb_write_reg),
    .i_exmem_reg_write(i_exmem_reg_write), .i_memwb_reg_write(i_memwb_reg_write),
    .i_exmem_branch(i_exmem_branch), .i_exmem_zero(i_exmem_zero),
    .i_exmem_mem_access(i_exmem_mem_access), .i_dmem_ready(i_dmem_ready),
    .o_pc_write(o_pc_write), .o_ifid_write(o_ifid_write), .o_if_flush(o_if_flush),
    .o_id_bubble(o_id_bubble), .o_ex_flush(o_ex_flush), .o_pc_src(o_pc_src),
    .o_pipe_hold(o_pipe_hold), .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b),
    .o_mem_err(o_mem_err), .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt),
    .o_wait_cnt(o_wait_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_ifid_rs = 0; i_ifid_rt = 0; i_idex_rs = 0; i_idex_rt = 0;
    i_idex_mem_read = 0; i_exmem_write_reg = 0; i_memwb_write_reg = 0;
    i_exmem_reg_write = 0; i_memwb_reg_write = 0; i_exmem_branch = 0;
    i_exmem_zero = 0; i_exmem_mem_access = 0; i_dmem_ready = 0;
  endtask

  function automatic logic [31:0] pc(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  initial begin
    clear_inputs();
    i_rst_n = 1'b0;
    tick(); tick();
    // Reset state
    chk("rst_pc_write", 32'(o_pc_write), 1);
    chk("rst_ifid_write", 32'(o_ifid_write), 1);
    chk("rst_hold", 32'(o_pipe_hold), 0);
    chk("rst_ctrl", 32'({o_if_flush, o_id_bubble, o_ex_flush, o_pc_src}), 0);
    chk("rst_fwd", 32'({o_fwd_a, o_fwd_b}), 0);
    chk("rst_mem_err", 32'(o_mem_err), 0);
    chk("rst_cnts", 32'({o_stall_cnt, o_flush_cnt}) | 32'(o_wait_cnt), 0);
    i_rst_n = 1'b1;
    tick();

    // Load-use: lw rt=5 in EX, rs=5 in ID -> one stall cycle
    i_idex_mem_read = 1; i_idex_rt = 5; i_ifid_rs = 5; #1;
    chk("lu_pc_write", 32'(o_pc_write), 0);
    chk("lu_ifid_write", 32'(o_ifid_write), 0);
    chk("lu_bubble", 32'(o_id_bubble), 1);
    chk("lu_flush", 32'({o_if_flush, o_ex_flush, o_pc_src, o_pipe_hold}), 0);
    tick();
    i_idex_mem_read = 0; i_idex_rt = 0; #1;  // bubble now in EX
    chk("lu_after_pc_write", 32'(o_pc_write), 1);
    chk("lu_after_bubble", 32'(o_id_bubble), 0);
    chk("lu_stall_cnt", 32'(o_stall_cnt), pc(1));
    // Load-use via rt match
    i_idex_mem_read = 1; i_idex_rt = 9; i_ifid_rt = 9; #1;
    chk("lu_rt_bubble", 32'(o_id_bubble), 1);
    tick();
    chk("lu_rt_stall_cnt", 32'(o_stall_cnt), pc(2));
    // Load with rt=0 never stalls
    i_idex_rt = 0; i_ifid_rs = 0; i_ifid_rt = 0; #1;
    chk("lu_r0_pc_write", 32'(o_pc_write), 1);
    chk("lu_r0_bubble", 32'(o_id_bubble), 0);
    tick();

    // Branch taken with simultaneous load-use: flush only
    i_idex_rt = 5; i_ifid_rs = 5; i_exmem_branch = 1; i_exmem_zero = 1; #1;
    chk("br_ctrl", 32'({o_pc_src, o_if_flush, o_id_bubble, o_ex_flush, o_pc_write}), 32'h1f);
    chk("br_hold", 32'(o_pipe_hold), 0);
    tick();
    chk("br_stall_cnt", 32'(o_stall_cnt), pc(2));
    chk("br_flush_cnt", 32'(o_flush_cnt), pc(1));
    // Branch not taken: load-use stall applies
    i_exmem_zero = 0; #1;
    chk("br_nt_pc_src", 32'(o_pc_src), 0);
    chk("br_nt_bubble", 32'(o_id_bubble), 1);
    clear_inputs();
    tick();

    // Forwarding
    i_exmem_reg_write = 1; i_exmem_write_reg = 7;
    i_memwb_reg_write = 1; i_memwb_write_reg = 7; i_idex_rs = 7; #1;
    chk("fwd_a_both", 32'(o_fwd_a), 2);
    chk("fwd_b_none", 32'(o_fwd_b), 0);
    i_exmem_reg_write = 0; i_idex_rt = 7; #1;
    chk("fwd_a_memwb", 32'(o_fwd_a), 1);
    chk("fwd_b_memwb", 32'(o_fwd_b), 1);
    i_exmem_reg_write = 1; i_exmem_write_reg = 0; i_memwb_write_reg = 0; i_idex_rs = 0; i_idex_rt = 0; #1;
    chk("fwd_r0", 32'({o_fwd_a, o_fwd_b}), 0);
    i_exmem_write_reg = 3; i_idex_rt = 3; i_exmem_mem_access = 1; #1;
    chk("fwd_b_held", 32'(o_fwd_b), 2);  // valid while held
    clear_inputs();
    tick();

    // Memory wait: 3 not-ready cycles with a pending taken branch
    i_exmem_mem_access = 1; i_dmem_ready = 0; i_exmem_branch = 1; i_exmem_zero = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_hold", 32'({o_pipe_hold, o_pc_write, o_ifid_write}), 32'b100);
      chk("mw_br_supp", 32'({o_pc_src, o_if_flush, o_id_bubble, o_ex_flush}), 0);
      tick();
    end
    i_dmem_ready = 1; #1;
    chk("mw_release_hold", 32'(o_pipe_hold), 0);
    chk("mw_release_br", 32'(o_pc_src), 1);
    tick();
    chk("mw_wait_cnt", 32'(o_wait_cnt), pc(3));
    chk("mw_flush_cnt", 32'(o_flush_cnt), pc(2));
    chk("mw_mem_err", 32'(o_mem_err), 0);
    i_exmem_branch = 0; i_exmem_zero = 0;

    // Boundary: exactly WAIT_MAX=4 not-ready cycles tolerated
    i_dmem_ready = 0;
    for (int i = 0; i < 4; i++) tick();
    i_dmem_ready = 1; #1;
    chk("wm_ready_hold", 32'(o_pipe_hold), 0);
    tick();
    chk("wm_mem_err", 32'(o_mem_err), 0);
    chk("wm_wait_cnt", 32'(o_wait_cnt), pc(7));

    // Timeout: 5th consecutive not-ready cycle enters ERR
    i_dmem_ready = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("to_err_before", 32'(o_mem_err), 0);
    tick();
    chk("to_err", 32'(o_mem_err), 1);
    i_dmem_ready = 1; #1;
    chk("to_hold_sticky", 32'({o_pipe_hold, o_pc_write, o_ifid_write}), 32'b100);
    tick();
    chk("to_err_sticky", 32'(o_mem_err), 1);
    chk("to_wait_cnt", 32'(o_wait_cnt), pc(13));

    // Async reset out of ERR
    #2 i_rst_n = 1'b0; #1;
    chk("rr_mem_err", 32'(o_mem_err), 0);
    chk("rr_hold", 32'(o_pipe_hold), 0);
    chk("rr_cnts", 32'(o_stall_cnt) | 32'(o_flush_cnt) | 32'(o_wait_cnt), 0);
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("rr_run_pc_write", 32'(o_pc_write), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard and pipeline-control unit for the 5-stage pipelined CPU. It reads the stage tags carried by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their write/flush/hold controls. It also drives the PC write enable and the ALU operand forwarding selects. It is the consumer of the pipeline registers' outputs and the producer of their control inputs, and adds a data-memory wait state machine with timeout.

## Interface
- WAIT_MAX, 15: maximum consecutive data-memory not-ready cycles before error (1..255).
- CNT_W, 16: width of the performance counters.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_ifid_rs, i_ifid_rt  in  5 each  source registers of the instruction in ID.
- i_idex_rs, i_idex_rt  in  5 each  source registers of the instruction in EX.
- i_idex_mem_read  in  1  EX instruction is a load.
- i_exmem_write_reg, i_memwb_write_reg  in  5 each  destination registers in MEM and WB.
- i_exmem_reg_write, i_memwb_reg_write  in  1 each  destination write enables in MEM and WB.
- i_exmem_branch, i_exmem_zero  in  1 each  branch instruction in MEM, and the ALU zero flag.
- i_exmem_mem_access  in  1  MEM instruction is a load or store.
- i_dmem_ready  in  1  data memory completes the access this cycle.
- o_pc_write  out  1  PC update enable.
- o_ifid_write  out  1  IF/ID write enable.
- o_if_flush  out  1  clear IF/ID.
- o_id_bubble  out  1  zero the control fields entering ID/EX.
- o_ex_flush  out  1  zero the control fields entering EX/MEM.
- o_pc_src  out  1  select the EX/MEM branch target as next PC.
- o_pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- o_fwd_a, o_fwd_b  out  2 each  ALU operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB data.
- o_mem_err  out  1  sticky data-memory timeout.
- o_stall_cnt, o_flush_cnt, o_wait_cnt  out  CNT_W each  performance counters.

## Operation
- Conditions:
  - taken = i_exmem_branch & i_exmem_zero.
  - loaduse = i_idex_mem_read & (i_idex_rt != 0) & (i_idex_rt == i_ifid_rs | i_idex_rt == i_ifid_rt).
  - mwait = i_exmem_mem_access & ~i_dmem_ready.
- FSM states are RUN, MWAIT and ERR; reset enters RUN.
- RUN transitions: mwait -> MWAIT, with wait count 1. Otherwise stay in RUN.
- MWAIT transitions: i_dmem_ready -> RUN, with wait count cleared. Otherwise the wait count increments; when it equals WAIT_MAX and the memory is still not ready -> ERR.
- ERR: stays until reset.
- Per-cycle outputs, in strict priority order (first match wins):
  1. ERR: o_pipe_hold=1, o_pc_write=0, o_ifid_write=0. All flush signals are 0.
  2. mwait (in RUN or MWAIT): same freeze as ERR. Branch and load-use are suppressed; the inputs are frozen, so they are re-evaluated on the release cycle.
  3. taken: o_pc_src=1 and o_pc_write=1. o_if_flush, o_id_bubble and o_ex_flush are all 1 (the three wrong-path instructions are squashed). Load-use is ignored.
  4. loaduse: o_pc_write=0, o_ifid_write=0, o_id_bubble=1. This is a one-cycle stall.
  5. Default: o_pc_write=1, o_ifid_write=1, all other controls 0.
- Forwarding is independent of the FSM and is valid even while held. For operand A (operand B is identical, using i_idex_rt):
  - 10 if i_exmem_reg_write & i_exmem_write_reg != 0 & i_exmem_write_reg == i_idex_rs.
  - Else 01 if the same condition holds on the MEM/WB fields.
  - Else 00.
  - EX/MEM wins when both stages match.
- o_mem_err is registered. It is set on entry to ERR and cleared only by reset.

## Timing
- All control outputs except o_mem_err are combinational from the current state and inputs, with zero latency. They act on the rising edge that ends the current cycle.
- Reset values:
  - State RUN, wait count 0, o_mem_err=0, all counters 0.
  - With all data inputs at 0, the combinational outputs are o_pc_write=1, o_ifid_write=1, all others 0.
- A reset assertion mid-MWAIT or in ERR returns immediately to RUN and clears o_mem_err and the counters.
- Memory wait: with WAIT_MAX=N, N consecutive not-ready cycles are tolerated. If cycle N+1 is still not ready, the state is ERR from the following edge; o_mem_err rises 1 cycle after the (N+1)th not-ready cycle.
- A ready on the Nth wait cycle returns to RUN with no error.
- When a branch is taken and there is a load-use on the same cycle, only the flush occurs; no stall cycle is added.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - o_stall_cnt increments on each loaduse stall cycle.
  - o_flush_cnt increments on each taken-flush cycle.
  - o_wait_cnt increments on each hold cycle (mwait or ERR).
  - All three saturate at all-ones; there is no wrap.
- HAZARD_PERF_CNT_EN undefined: no counter registers are built, and the three outputs are tied to 0.

## Test plan
- Load-use: ID/EX lw with rt=5; IF/ID rs=5 -> exactly one cycle of o_pc_write=0, o_ifid_write=0, o_id_bubble=1, then normal. With rt=0 -> no stall.
- Branch taken, with load-use on the same cycle: i_exmem_branch=1, i_exmem_zero=1 -> o_pc_src=1, o_if_flush=1, o_id_bubble=1, o_ex_flush=1, o_pc_write=1. o_stall_cnt unchanged, o_flush_cnt +1.
- Forwarding: EX/MEM and MEM/WB both write r7, i_idex_rs=7 -> o_fwd_a=10. With only MEM/WB writing r7 -> 01. With write_reg=0 -> 00.
- Memory wait: 3 not-ready cycles, then ready -> o_pipe_hold=1 for 3 cycles, then 0. o_wait_cnt=3, o_mem_err=0.
- Timeout with WAIT_MAX=4: ready held low -> o_mem_err=1 after the 5th not-ready cycle, and the hold stays 1 even when ready later rises. Asserting i_rst_n low clears the error, returns to RUN, and zeroes the counters.
- Build without HAZARD_PERF_CNT_EN: repeat the load-use test -> all counter outputs stay 0.
